// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared defaults, arbiter state encoding and requester indices
package mem_arb_pkg;
  localparam int AW_DEF = 12;
  localparam int DW_DEF = 16;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ISSUE  = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;
  localparam int REQ_CPU = 0;
  localparam int REQ_DBG = 1;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin one-hot picker, searching upward from ptr with wrap
module rr_pick #(
  parameter int N  = 2,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic [N-1:0]  mask,
  output logic [N-1:0]  gnt
);
  logic [N-1:0] cand;
  assign cand = req & mask;
  // scan offsets high-to-low so the candidate closest to ptr is the last to overwrite
  always_comb begin
    gnt = '0;
    for (int k = N - 1; k >= 0; k--)
      if (cand[(int'(ptr) + k) % N]) gnt = N'(1) << ((int'(ptr) + k) % N);
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter with bounded lock sharing the MU0 memory port
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int MAX_LOCK = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    rw,
  input  logic [N_REQ-1:0]    lock,
  input  logic [N_REQ*AW-1:0] addr,
  input  logic [N_REQ*DW-1:0] wdata,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    rvalid,
  output logic [DW-1:0]       rdata,
  output logic                mem_rw,
  output logic [AW-1:0]       mem_addr,
  output logic [DW-1:0]       mem_wdata,
  input  logic [DW-1:0]       mem_rdata,
  output logic                busy
);
  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_LOCK + 1);
  logic [1:0]       state;
  logic [PW-1:0]    ptr, owner, w;
  logic [CW-1:0]    cnt;
  logic [N_REQ-1:0] mask, rd_pend;
  logic             hold;
  assign hold = state == LOCKED && req[owner] && lock[owner] && cnt < CW'(MAX_LOCK);
  assign mask = !reset ? '0 : hold ? N_REQ'(1) << owner : '1;
  rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
    .req  (req),
    .ptr  (ptr),
    .mask (mask),
    .gnt  (gnt)
  );
  // encode the one-hot grant into the winner index
  always_comb begin
    w = '0;
    for (int i = 0; i < N_REQ; i++) if (gnt[i]) w = PW'(i);
  end
  // register the winner's command, return read data a cycle later, track lock ownership
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rvalid    <= '0;
      rdata     <= '0;
      mem_rw    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      rd_pend   <= '0;
      ptr       <= '0;
      owner     <= '0;
      cnt       <= '0;
      state     <= IDLE;
    end else begin
      rvalid  <= rd_pend;
      if (|rd_pend) rdata <= mem_rdata;
      busy    <= |gnt;
      mem_rw  <= |gnt & rw[w];
      rd_pend <= gnt & ~rw;
      if (|gnt) begin
        mem_addr  <= addr[w*AW +: AW];
        mem_wdata <= wdata[w*DW +: DW];
        ptr       <= (int'(w) == N_REQ - 1) ? '0 : w + 1'b1;
        owner     <= w;
        state     <= lock[w] ? LOCKED : ISSUE;
        cnt       <= !lock[w] ? '0 :
                     (state == LOCKED && owner == w) ? (cnt == CW'(MAX_LOCK) ? cnt : cnt + 1'b1) :
                     CW'(1);
      end else begin
        state <= IDLE;
        cnt   <= '0;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a negedge-registered memory model
module tb_mem_arbiter;
  import mem_arb_pkg::*;
  localparam int N = 2, AW = 12, DW = 16;
  typedef struct packed {
    logic [N-1:0]  port;
    logic [DW-1:0] data;
  } exp_t;
  logic clk = 1'b0, reset = 1'b0;
  logic [N-1:0] req, rw, lock, gnt, rvalid, exp_g;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic mem_rw, busy;
  logic [DW-1:0] mem [0:4095];
  exp_t q[$];
  exp_t e;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  mem_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .MAX_LOCK(4)) dut (
    .clk(clk), .reset(reset), .req(req), .rw(rw), .lock(lock), .addr(addr),
    .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_rw(mem_rw),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );
  // memory: acts on the falling edge, readdata is zero on a write
  always @(negedge clk) begin
    if (mem_rw) begin
      mem[mem_addr] <= mem_wdata;
      mem_rdata     <= '0;
    end else mem_rdata <= mem[mem_addr];
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic push(input logic [N-1:0] p, input logic [DW-1:0] d);
    exp_t x;
    x.port = p;
    x.data = d;
    q.push_back(x);
  endtask
  // monitor: every rvalid pulse must match the oldest expected read
  always @(posedge clk) begin
    #1;
    if (reset && rvalid != '0) begin
      if (q.size() == 0) chk("rvalid_unexpected", 32'(rvalid), 32'd0);
      else begin
        e = q.pop_front();
        chk("rvalid_port", 32'(rvalid), 32'(e.port));
        chk("rdata", 32'(rdata), 32'(e.data));
      end
    end
  end
  task automatic do_reset();
    @(negedge clk);
    req = '0; lock = '0; rw = '0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask
  task automatic single_read();
    @(negedge clk);
    req = 2'b01; rw = 2'b00; addr[0 +: AW] = 12'h005;
    #1 chk("t2_gnt", 32'(gnt), 32'b01);
    push(2'b01, 16'h1234);
    @(negedge clk);
    req = '0;
    #1 chk("t2_busy", 32'(busy), 32'd1);
    chk("t2_mem_addr", 32'(mem_addr), 32'h005);
    repeat (3) @(negedge clk);
  endtask
  initial begin
    req = '0; rw = '0; lock = '0; addr = '0; wdata = '0;
    for (int i = 0; i < 4096; i++) mem[i] <= '0;
    #0;
    mem[12'h005] <= 16'h1234;
    mem[12'h010] <= 16'hA0A0;
    mem[12'h020] <= 16'hB1B1;
    req = 2'b11;
    #12;
    chk("t1_gnt", 32'(gnt), 32'd0);
    chk("t1_rvalid", 32'(rvalid), 32'd0);
    chk("t1_mem_rw", 32'(mem_rw), 32'd0);
    chk("t1_mem_addr", 32'(mem_addr), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_rdata", 32'(rdata), 32'd0);
    @(negedge clk);
    req = '0;
    reset = 1'b1;
    single_read();
    do_reset();
    @(negedge clk);
    req = 2'b11; rw = 2'b00; addr = {12'h020, 12'h010};
    #1;
    for (int i = 0; i < 6; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      chk("t3_gnt", 32'(gnt), 32'(exp_g));
      if (i > 0) chk("t3_busy", 32'(busy), 32'd1);
      push(exp_g, exp_g == 2'b01 ? 16'hA0A0 : 16'hB1B1);
      @(negedge clk);
      #1;
    end
    req = '0;
    repeat (3) @(negedge clk);
    req = 2'b10; rw = 2'b10; addr[AW +: AW] = 12'hFFF; wdata[DW +: DW] = 16'hBEEF;
    #1 chk("t4_wr_gnt", 32'(gnt), 32'b10);
    @(negedge clk);
    rw = 2'b00;
    #1 chk("t4_rd_gnt", 32'(gnt), 32'b10);
    chk("t4_mem_rw", 32'(mem_rw), 32'd1);
    chk("t4_mem_wdata", 32'(mem_wdata), 32'hBEEF);
    push(2'b10, 16'hBEEF);
    @(negedge clk);
    req = '0;
    repeat (3) @(negedge clk);
    do_reset();
    @(negedge clk);
    req = 2'b11; lock = 2'b01; rw = 2'b00; addr = {12'h020, 12'h010};
    #1;
    for (int i = 0; i < 5; i++) begin
      exp_g = (i < 4) ? 2'b01 : 2'b10;
      chk("t5_gnt", 32'(gnt), 32'(exp_g));
      push(exp_g, exp_g == 2'b01 ? 16'hA0A0 : 16'hB1B1);
      @(negedge clk);
      #1;
    end
    req = '0; lock = '0;
    repeat (3) @(negedge clk);
    do_reset();
    @(negedge clk);
    req = 2'b01; rw = 2'b00; addr[0 +: AW] = 12'h005;
    #1 chk("t6_gnt", 32'(gnt), 32'b01);
    @(negedge clk);
    req = '0;
    reset = 1'b0;
    #1 chk("t6_mem_rw", 32'(mem_rw), 32'd0);
    @(posedge clk);
    #2 chk("t6_rvalid", 32'(rvalid), 32'd0);
    chk("t6_mem_rw_hold", 32'(mem_rw), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    single_read();
    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
